// File: rtl/pagerank_pkg.sv
// Shared types and fixed-point helpers for the PageRank scatter engine.
package pagerank_pkg;

  localparam int PR_W   = 64;
  localparam int INV_W  = 32;
  localparam int ID_W   = 32;
  localparam int FRAC_W = 32;

  typedef logic [PR_W-1:0]  pr_t;
  typedef logic [INV_W-1:0] inv_t;
  typedef logic [ID_W-1:0]  node_id_t;

  typedef enum logic [1:0] {
    IDLE,
    SCATTER,
    DRAIN,
    DONE
  } scatter_state_t;

  typedef struct packed {
    pr_t      pr;
    inv_t     inv;
    node_id_t dst;
    logic     last;
    logic     valid;
  } s1_payload_t;

  // Q32.32 x Q0.32 -> Q32.64; keep Q32.32 by dropping FRAC_W low bits.
  function automatic pr_t fx_mul(input pr_t pr, input inv_t inv);
    logic [PR_W+INV_W-1:0] prod;
    prod = {{INV_W{1'b0}}, pr} * {{PR_W{1'b0}}, inv};
    return prod[PR_W+FRAC_W-1:FRAC_W];
  endfunction

endpackage

// File: rtl/pagerank_scatter_pipe.sv
// Two-stage scatter datapath: rank/degree lookup, then multiply into the
// output registers. Flush kills every in-flight token without emitting it.
module pagerank_scatter_pipe
  import pagerank_pkg::*;
#(
  parameter int NODES_IN_GRAPH = 4,
  parameter int IDX_W          = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic                 last_i,
  input  logic [IDX_W-1:0]     src_idx_i,
  input  node_id_t             dst_i,
  input  pr_t                  pagerank_curr_i [NODES_IN_GRAPH],
  input  inv_t                 inv_out_degree_i [NODES_IN_GRAPH],
  output logic                 s1_valid_o,
  output logic                 s1_last_o,
  output pr_t                  value_o,
  output node_id_t             dest_o,
  output logic                 ready_o
);

  s1_payload_t s1_q, s1_d;
  pr_t         value_q, value_d;
  node_id_t    dest_q, dest_d;
  logic        ready_q, ready_d;

  // Stage-1 capture; valid_i already excludes out-of-range ids, so the
  // lookup index is only trusted when valid_i is high.
  always_comb begin
    s1_d = '0;
    if (!flush_i) begin
      s1_d.valid = valid_i;
      s1_d.last  = last_i;
      if (valid_i) begin
        s1_d.pr  = pagerank_curr_i[src_idx_i];
        s1_d.inv = inv_out_degree_i[src_idx_i];
        s1_d.dst = dst_i;
      end
    end
  end

  // Stage-2 multiply; value and destination hold between beats.
  always_comb begin
    value_d = value_q;
    dest_d  = dest_q;
    ready_d = 1'b0;
    if (!flush_i && s1_q.valid) begin
      value_d = fx_mul(s1_q.pr, s1_q.inv);
      dest_d  = s1_q.dst;
      ready_d = 1'b1;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= '0;
      value_q <= '0;
      dest_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      value_q <= value_d;
      dest_q  <= dest_d;
      ready_q <= ready_d;
    end
  end

  assign s1_valid_o = s1_q.valid;
  assign s1_last_o  = s1_q.last;
  assign value_o    = value_q;
  assign dest_o     = dest_q;
  assign ready_o    = ready_q;

endmodule

// File: rtl/pagerank_scatter.sv
// Scatter-phase engine: sequences one pass over the edge stream and emits
// one contribution beat per in-range edge, two edges after acceptance.
//
// state   | meaning
// IDLE    | disabled or aborted, waiting for a start pulse
// SCATTER | accepting edges until the one flagged last
// DRAIN   | last edge in flight, no more edges accepted
// DONE    | pass finished, complete held high until next start
module pagerank_scatter
  import pagerank_pkg::*;
#(
  parameter int NODES_IN_GRAPH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pagerank_enable,
  input  logic        nextIteration,
  input  logic        edge_valid,
  output logic        edge_ready,
  input  node_id_t    edge_src,
  input  node_id_t    edge_dst,
  input  logic        edge_last,
  input  pr_t         pagerank_curr [NODES_IN_GRAPH],
  input  inv_t        inv_out_degree [NODES_IN_GRAPH],
  output pr_t         page_rank_scatter,
  output node_id_t    dest_id,
  output logic        pagerank_ready,
  output logic        scatter_operation_complete,
  output logic [31:0] edge_count,
  output logic        range_error
);

  localparam int IDX_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;

  scatter_state_t state_q, state_d;
  logic [31:0]    count_q, count_d;
  logic           rerr_q, rerr_d;
  logic           complete_q, complete_d;

  logic accept, in_range, start, flush;
  logic s1_valid, s1_last;

  assign edge_ready = (state_q == SCATTER);
  assign accept     = edge_valid & edge_ready;
  assign in_range   = (edge_src < ID_W'(NODES_IN_GRAPH)) &&
                      (edge_dst < ID_W'(NODES_IN_GRAPH));
  assign start      = nextIteration & pagerank_enable &
                      ((state_q == IDLE) || (state_q == DONE));
  assign flush      = ~pagerank_enable;

  pagerank_scatter_pipe #(
    .NODES_IN_GRAPH(NODES_IN_GRAPH),
    .IDX_W         (IDX_W)
  ) u_pipe (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush_i         (flush),
    .valid_i         (accept & in_range),
    .last_i          (accept & edge_last),
    .src_idx_i       (edge_src[IDX_W-1:0]),
    .dst_i           (edge_dst),
    .pagerank_curr_i (pagerank_curr),
    .inv_out_degree_i(inv_out_degree),
    .s1_valid_o      (s1_valid),
    .s1_last_o       (s1_last),
    .value_o         (page_rank_scatter),
    .dest_o          (dest_id),
    .ready_o         (pagerank_ready)
  );

  // Next-state logic; disable overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCATTER;
      SCATTER: if (accept && edge_last) state_d = DRAIN;
      DRAIN:   if (s1_last) state_d = DONE;
      DONE:    if (start) state_d = SCATTER;
      default: state_d = IDLE;
    endcase
    if (!pagerank_enable) state_d = IDLE;
  end

  // Pass bookkeeping: beat counter, sticky range error, completion flag.
  // Count and completion are updated on the same edge that loads the
  // output registers, so they line up with pagerank_ready.
  always_comb begin
    count_d    = count_q;
    rerr_d     = rerr_q;
    complete_d = complete_q;
    if (start) begin
      count_d    = '0;
      rerr_d     = 1'b0;
      complete_d = 1'b0;
    end else begin
      if (s1_valid && pagerank_enable && (count_q != '1)) count_d = count_q + 32'd1;
      if (accept && !in_range) rerr_d = 1'b1;
      if (s1_last && pagerank_enable) complete_d = 1'b1;
    end
    if (!pagerank_enable) complete_d = 1'b0;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rerr_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rerr_q     <= rerr_d;
      complete_q <= complete_d;
    end
  end

  assign edge_count                 = count_q;
  assign range_error                = rerr_q;
  assign scatter_operation_complete = complete_q;

endmodule

// File: tb/tb_pagerank_scatter.sv
// Directed bench for pagerank_scatter. An edge accepted at rising edge N is
// consumed by the gather side at edge N+2, so outputs are sampled 1 ns after
// edge N+1, i.e. the value that edge N+2 sees.
module tb_pagerank_scatter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pagerank_enable;
  logic        nextIteration;
  logic        edge_valid;
  logic        edge_ready;
  logic [31:0] edge_src;
  logic [31:0] edge_dst;
  logic        edge_last;
  logic [63:0] pagerank_curr [4];
  logic [31:0] inv_out_degree [4];
  logic [63:0] page_rank_scatter;
  logic [31:0] dest_id;
  logic        pagerank_ready;
  logic        scatter_operation_complete;
  logic [31:0] edge_count;
  logic        range_error;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  pagerank_scatter #(.NODES_IN_GRAPH(4)) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .pagerank_enable           (pagerank_enable),
    .nextIteration             (nextIteration),
    .edge_valid                (edge_valid),
    .edge_ready                (edge_ready),
    .edge_src                  (edge_src),
    .edge_dst                  (edge_dst),
    .edge_last                 (edge_last),
    .pagerank_curr             (pagerank_curr),
    .inv_out_degree            (inv_out_degree),
    .page_rank_scatter         (page_rank_scatter),
    .dest_id                   (dest_id),
    .pagerank_ready            (pagerank_ready),
    .scatter_operation_complete(scatter_operation_complete),
    .edge_count                (edge_count),
    .range_error               (range_error)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic        last;
    logic        exp_rdy;
    logic [63:0] exp_val;
    logic [31:0] exp_dst;
  } vec_t;

  vec_t tv [11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Starts a pass, streams tv[first..last_idx] back to back and checks
  // each entry's beat one edge after its acceptance edge.
  task automatic run_pass(input int first, input int last_idx);
    int   cnt;
    logic rerr;
    cnt  = 0;
    rerr = 1'b0;
    nextIteration = 1'b1;
    tick();
    nextIteration = 1'b0;
    check("start_complete", 64'(scatter_operation_complete), 64'd0);
    check("start_count", 64'(edge_count), 64'd0);
    check("start_rerr", 64'(range_error), 64'd0);
    check("start_edge_ready", 64'(edge_ready), 64'd1);
    for (int k = first; k <= last_idx + 1; k++) begin
      if (k <= last_idx) begin
        edge_valid = 1'b1;
        edge_src   = tv[k].src;
        edge_dst   = tv[k].dst;
        edge_last  = tv[k].last;
        if (tv[k].src >= 32'd4 || tv[k].dst >= 32'd4) rerr = 1'b1;
      end else begin
        edge_valid = 1'b0;
        edge_last  = 1'b0;
      end
      tick();
      if (k - 1 >= first) begin
        int j;
        j = k - 1;
        check($sformatf("v%0d_ready", j), 64'(pagerank_ready), 64'(tv[j].exp_rdy));
        if (tv[j].exp_rdy) begin
          cnt++;
          check($sformatf("v%0d_value", j), page_rank_scatter, tv[j].exp_val);
          check($sformatf("v%0d_dest", j), 64'(dest_id), 64'(tv[j].exp_dst));
        end
        check($sformatf("v%0d_complete", j), 64'(scatter_operation_complete), 64'(j == last_idx));
        check($sformatf("v%0d_count", j), 64'(edge_count), 64'(cnt));
      end
    end
    check("pass_rerr", 64'(range_error), 64'(rerr));
    check("pass_done_edge_ready", 64'(edge_ready), 64'd0);
    tick();
    check("done_ready_low", 64'(pagerank_ready), 64'd0);
    check("done_complete_held", 64'(scatter_operation_complete), 64'd1);
  endtask

  initial begin
    // Back-to-back stream: 3.0 * 1/3 truncates to 0xFFFF_FFFF.
    for (int i = 0; i < 5; i++)
      tv[i] = '{32'd1, 32'd3, (i == 4), 1'b1, 64'h0000_0000_FFFF_FFFF, 32'd3};
    // Dangling source gives a zero beat; out-of-range source gives none.
    tv[5]  = '{32'd3, 32'd1, 1'b0, 1'b1, 64'h0, 32'd1};
    tv[6]  = '{32'd7, 32'd1, 1'b1, 1'b0, 64'h0, 32'd0};
    // Mixed pass with an out-of-range destination in the middle.
    tv[7]  = '{32'd2, 32'd0, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 32'd0};
    tv[8]  = '{32'd0, 32'd3, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 32'd3};
    tv[9]  = '{32'd1, 32'd5, 1'b0, 1'b0, 64'h0, 32'd0};
    tv[10] = '{32'd1, 32'd2, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 32'd2};

    pagerank_curr[0]  = 64'h0000_0001_0000_0000;
    pagerank_curr[1]  = 64'h0000_0003_0000_0000;
    pagerank_curr[2]  = 64'h0000_0002_0000_0000;
    pagerank_curr[3]  = 64'h0000_0001_8000_0000;
    inv_out_degree[0] = 32'h8000_0000;
    inv_out_degree[1] = 32'h5555_5555;
    inv_out_degree[2] = 32'h4000_0000;
    inv_out_degree[3] = 32'h0000_0000;

    reset_n         = 1'b0;
    pagerank_enable = 1'b0;
    nextIteration   = 1'b0;
    edge_valid      = 1'b0;
    edge_src        = '0;
    edge_dst        = '0;
    edge_last       = 1'b0;
    #12;
    check("rst_value", page_rank_scatter, 64'd0);
    check("rst_dest", 64'(dest_id), 64'd0);
    check("rst_ready", 64'(pagerank_ready), 64'd0);
    check("rst_complete", 64'(scatter_operation_complete), 64'd0);
    check("rst_count", 64'(edge_count), 64'd0);
    check("rst_rerr", 64'(range_error), 64'd0);
    check("rst_edge_ready", 64'(edge_ready), 64'd0);
    reset_n         = 1'b1;
    pagerank_enable = 1'b1;
    tick();

    // Edges offered in IDLE are not taken.
    edge_valid = 1'b1;
    edge_src   = 32'd0;
    edge_dst   = 32'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_edge_ready", 64'(edge_ready), 64'd0);
      check("idle_ready", 64'(pagerank_ready), 64'd0);
    end

    // Single edge 0->2: 1.0 * 0.5.
    edge_valid    = 1'b0;
    nextIteration = 1'b1;
    tick();
    nextIteration = 1'b0;
    edge_valid    = 1'b1;
    edge_last     = 1'b1;
    tick();
    edge_valid    = 1'b0;
    edge_last     = 1'b0;
    check("single_pre_ready", 64'(pagerank_ready), 64'd0);
    nextIteration = 1'b1;
    tick();
    nextIteration = 1'b0;
    check("single_ready", 64'(pagerank_ready), 64'd1);
    check("single_value", page_rank_scatter, 64'h0000_0000_8000_0000);
    check("single_dest", 64'(dest_id), 64'd2);
    check("single_complete", 64'(scatter_operation_complete), 64'd1);
    check("single_count", 64'(edge_count), 64'd1);
    tick();
    check("single_after_ready", 64'(pagerank_ready), 64'd0);
    check("single_after_value_hold", page_rank_scatter, 64'h0000_0000_8000_0000);
    check("single_after_complete", 64'(scatter_operation_complete), 64'd1);

    run_pass(0, 4);
    run_pass(5, 6);
    run_pass(7, 10);

    // Abort: disable right after the second accepted edge.
    nextIteration = 1'b1;
    tick();
    nextIteration = 1'b0;
    edge_valid = 1'b1;
    edge_src   = 32'd1;
    edge_dst   = 32'd3;
    tick();
    tick();
    check("abort_first_beat", 64'(pagerank_ready), 64'd1);
    edge_valid      = 1'b0;
    pagerank_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_ready", 64'(pagerank_ready), 64'd0);
      check("abort_complete", 64'(scatter_operation_complete), 64'd0);
      check("abort_edge_ready", 64'(edge_ready), 64'd0);
    end
    check("abort_count_hold", 64'(edge_count), 64'd1);

    // Asynchronous reset in the middle of a pass.
    pagerank_enable = 1'b1;
    nextIteration   = 1'b1;
    tick();
    nextIteration = 1'b0;
    edge_valid    = 1'b1;
    tick();
    tick();
    check("midrst_pre_ready", 64'(pagerank_ready), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_value", page_rank_scatter, 64'd0);
    check("midrst_dest", 64'(dest_id), 64'd0);
    check("midrst_ready", 64'(pagerank_ready), 64'd0);
    check("midrst_count", 64'(edge_count), 64'd0);
    check("midrst_edge_ready", 64'(edge_ready), 64'd0);
    edge_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_pass(7, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
